irda_sir_encoder: RTL and testbench
===================================

Name: irda_sir_encoder

Overview:
- SIR (up to 115.2 kbaud) transmit path for the IrDA core: byte in, IR LED pulse stream out.
- Accepts bytes from the transmit FIFO/UART side via a valid/ready handshake and frames each one as start + data (LSB first) + stop bits.
- Each 0 bit is emitted as an RZI pulse; each 1 bit produces no pulse.
- Timebase is the shared 16x baud enable (fast_enable). The block idles when the core is in MIR/FIR mode or in receive direction.

Parameters:
- DATA_BITS, 8, data bits per frame (5..8).
- STOP_BITS, 1, stop bits per frame (1..2).
- PULSE_WIDTH, 3, pulse length in 16x ticks (3 = 3/16 bit cell).
- MIN_PULSE_CYCLES, 8, fixed pulse length in clk cycles; used only with IRDA_SIR_MIN_PULSE_EN.

Ports:
- clk  in  1  system clock.
- wb_rst_i  in  1  reset.
- fast_enable  in  1  16x baud tick, one clk wide.
- tx_select  in  1  1 = transmit direction selected.
- fast_mode  in  1  1 = MIR/FIR active; SIR block held idle.
- tx_data  in  DATA_BITS  byte to send.
- tx_valid  in  1  tx_data valid.
- tx_ready  out  1  holding register empty; transfer on tx_valid & tx_ready at a clk edge.
- sir_enc_o  out  1  IR LED drive, active high.
- tx_busy  out  1  frame in progress (state != IDLE).
- tx_done  out  1  one-clk pulse at end of last stop bit.

Behaviour:
- Interface: reset wb_rst_i, asynchronous, active-high; clock clk.
- Reset values: state IDLE, cnt16 0, bit index 0, hold_full 0, shift 0, sir_enc_o 0, tx_done 0, tx_busy 0.
- Sync clear: while fast_mode=1 or tx_select=0, every clk forces the reset values.
  - Any frame in flight is aborted with no partial stop bit.
  - Any held byte is discarded.
- tx_ready = ~hold_full & tx_select & ~fast_mode (combinational).
  - Accept sets hold_full and latches tx_data into hold.
  - Accept is legal in any state, which gives one-byte buffering.
- cnt16 is 4 bits. It increments on every fast_enable while state != IDLE and wraps 15→0. A bit cell is exactly 16 ticks.
- FSM states: IDLE, START, DATA, STOP. Transitions occur only on fast_enable:
  - IDLE: if hold_full → START; shift ← hold; hold_full ← 0; cnt16 ← 0.
  - START, cnt16=15 → DATA, index 0.
  - DATA, cnt16=15: shift right, index+1. At index DATA_BITS-1 → STOP, stop count 0.
  - STOP, cnt16=15: at last stop bit, assert tx_done for that clk.
    - If hold_full, go directly to START with the new byte (zero-gap back-to-back).
    - Otherwise go to IDLE.
  - Same-edge accept and final-stop-bit tick: the byte accepted that edge is not seen. The FSM goes to IDLE and starts on the next tick.
- Current bit: START=0, DATA=shift[0], STOP=1.
- sir_enc_o is a flop, updated every clk to (state in START/DATA) & (current bit=0) & (cnt16 < PULSE_WIDTH). It lags state/cnt16 by one clk.
  - The pulse sits at the start of the bit cell.
  - Pulse length = PULSE_WIDTH tick periods.
- fast_enable deasserted: all counters hold.

Optional Feature:
- Macro: IRDA_SIR_MIN_PULSE_EN.
- Defined:
  - A pulse starts on the clk after the tick that sets cnt16=0 in a 0 bit.
  - It lasts MIN_PULSE_CYCLES clk cycles, counted by an 8-bit down-counter independent of fast_enable. This is the 1.6 µs fixed-pulse mode.
  - The pulse is truncated if the bit cell ends first.
  - The down-counter is cleared by reset and by the sync clear.
- Undefined: 3/16 pulse as above; down-counter and MIN_PULSE_CYCLES unused.

Decomposition:
- Shared package irda_pkg holds:
  - FSM state encoding (IDLE/START/DATA/STOP, 2 bits).
  - Constant SIR_OVERSAMPLE = 16.
  - Default PULSE_WIDTH.
  - The state encoding, reused by the decoder-side debug.
- One natural sub-module: irda_sir_pulse_gen, which turns the bit value, cnt16 and the macro-selected pulse counter into sir_enc_o.
- Framing FSM and holding register stay in the top.

Test Plan:
- Byte 0x55, fast_enable every 4 clk:
  - Expect pulses in start and bits 1,3,5,7: five pulses, each 12 clk high.
  - Frame = 160 ticks; tx_done once; tx_busy low afterwards.
- Byte 0xFF → start-bit pulse only. Byte 0x00 → 9 pulses, one every 64 clk.
- Bytes 0xA3 then 0x3C, second offered while the first is in DATA:
  - tx_ready drops until the first byte loads.
  - The second start bit begins at the tick right after the first stop bit, with no idle cells.
- fast_mode raised mid-DATA:
  - sir_enc_o 0 within 1 clk; tx_busy 0; hold emptied; tx_ready 0 until fast_mode falls.
- wb_rst_i pulsed mid-pulse → sir_enc_o 0 asynchronously; after release, tx_select=0 keeps tx_ready 0.
- With IRDA_SIR_MIN_PULSE_EN, MIN_PULSE_CYCLES=8, tick every 20 clk, byte 0x00 → each pulse exactly 8 clk.

Source files
------------

// File: rtl/irda_pkg.sv
// Shared IrDA definitions: SIR framing state encoding and timing constants.
// Pure declarations, no latency.
// No flow control here; the encoder, and the decoder-side debug, import these.
package irda_pkg;

  // SIR framing FSM encoding, 2 bits
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } sir_state_t;

  // 16x oversampling: a SIR bit cell is exactly 16 baud ticks
  localparam int SIR_OVERSAMPLE = 16;

  // Default RZI pulse width in 16x ticks (3/16 of a bit cell)
  localparam int SIR_PULSE_WIDTH_DEF = 3;

  // States whose bit cells can carry a pulse (start and data; stop is always 1)
  function automatic logic sir_pulse_state(input sir_state_t s);
    return (s == ST_START) || (s == ST_DATA);
  endfunction

endpackage

// File: rtl/irda_sir_pulse_gen.sv
// SIR RZI pulse shaper: turns "inside a 0-bit cell" plus the 16x cell counter into the LED drive.
// Output registered, one clk behind the framing state; IRDA_SIR_MIN_PULSE_EN selects a fixed clk-count pulse.
// No handshake; cleared asynchronously by wb_rst_i and synchronously by sync_clr.
module irda_sir_pulse_gen
  import irda_pkg::*;
#(
  parameter int PULSE_WIDTH      = SIR_PULSE_WIDTH_DEF,
  parameter int MIN_PULSE_CYCLES = 8
) (
  input  logic       clk,
  input  logic       wb_rst_i,
  input  logic       sync_clr,
  input  logic       zero_cell,
  input  logic [3:0] cnt16,
  output logic       sir_enc_o
);

`ifdef IRDA_SIR_MIN_PULSE_EN
  localparam logic [7:0] MIN_CYC = 8'(MIN_PULSE_CYCLES);

  logic [3:0] unused_pulse_width;
  logic [7:0] pulse_cnt;
  logic       at_cell0;
  logic       at_cell0_q;

  assign unused_pulse_width = 4'(PULSE_WIDTH);

  // First clk of a 0-bit cell: cnt16 is 0 now but was not last clk
  assign at_cell0 = zero_cell & (cnt16 == 4'd0);

  // Fixed-length pulse from an 8-bit down-counter, cut short if the 0-bit cell ends
  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      pulse_cnt  <= 8'd0;
      at_cell0_q <= 1'b0;
      sir_enc_o  <= 1'b0;
    end else if (sync_clr) begin
      pulse_cnt  <= 8'd0;
      at_cell0_q <= 1'b0;
      sir_enc_o  <= 1'b0;
    end else begin
      at_cell0_q <= at_cell0;
      if (at_cell0 && !at_cell0_q) begin
        pulse_cnt <= MIN_CYC;
        sir_enc_o <= (MIN_CYC != 8'd0);
      end else begin
        if (pulse_cnt != 8'd0) pulse_cnt <= pulse_cnt - 8'd1;
        sir_enc_o <= zero_cell & (pulse_cnt > 8'd1);
      end
    end
  end
`else
  localparam logic [3:0] PW = 4'(PULSE_WIDTH);

  logic [7:0] unused_min_pulse;

  assign unused_min_pulse = 8'(MIN_PULSE_CYCLES);

  // Pulse covers the first PULSE_WIDTH ticks of every 0-bit cell
  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      sir_enc_o <= 1'b0;
    end else if (sync_clr) begin
      sir_enc_o <= 1'b0;
    end else begin
      sir_enc_o <= zero_cell & (cnt16 < PW);
    end
  end
`endif

endmodule

// File: rtl/irda_sir_encoder.sv
// IrDA SIR transmit encoder: byte in, start/data(LSB first)/stop framing, RZI pulse per 0 bit; macro IRDA_SIR_MIN_PULSE_EN.
// Frame = (1+DATA_BITS+STOP_BITS)*16 fast_enable ticks; LED output one clk behind the FSM.
// tx_ready low while the one-byte holding register is full or the SIR path is not selected.
module irda_sir_encoder
  import irda_pkg::*;
#(
  parameter int DATA_BITS        = 8,
  parameter int STOP_BITS        = 1,
  parameter int PULSE_WIDTH      = SIR_PULSE_WIDTH_DEF,
  parameter int MIN_PULSE_CYCLES = 8
) (
  input  logic                 clk,
  input  logic                 wb_rst_i,
  input  logic                 fast_enable,
  input  logic                 tx_select,
  input  logic                 fast_mode,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 sir_enc_o,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam logic [3:0] LAST_TICK = 4'(SIR_OVERSAMPLE - 1);
  localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
  localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

  sir_state_t           state;
  logic [3:0]           cnt16;
  logic [2:0]           bit_idx;
  logic                 stop_idx;
  logic [DATA_BITS-1:0] hold;
  logic                 hold_full;
  logic [DATA_BITS-1:0] shift;
  logic                 sync_clr;
  logic                 accept;
  logic                 cur_bit;
  logic                 zero_cell;
  logic                 cell_end;

  // SIR path is idle whenever MIR/FIR owns the link or we are receiving
  assign sync_clr = fast_mode | ~tx_select;
  assign tx_ready = ~hold_full & tx_select & ~fast_mode;
  assign accept   = tx_valid & tx_ready;
  assign tx_busy  = (state != ST_IDLE);
  assign cell_end = fast_enable & (cnt16 == LAST_TICK);

  // Value of the bit cell currently being sent
  always_comb begin
    cur_bit = 1'b1;
    case (state)
      ST_START: cur_bit = 1'b0;
      ST_DATA:  cur_bit = shift[0];
      default:  cur_bit = 1'b1;
    endcase
  end

  assign zero_cell = sir_pulse_state(state) & ~cur_bit;

  // Holding register plus framing FSM; a full hold at stop end chains frames with no gap
  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state     <= ST_IDLE;
      cnt16     <= 4'd0;
      bit_idx   <= 3'd0;
      stop_idx  <= 1'b0;
      hold      <= '0;
      hold_full <= 1'b0;
      shift     <= '0;
      tx_done   <= 1'b0;
    end else if (sync_clr) begin
      state     <= ST_IDLE;
      cnt16     <= 4'd0;
      bit_idx   <= 3'd0;
      stop_idx  <= 1'b0;
      hold      <= '0;
      hold_full <= 1'b0;
      shift     <= '0;
      tx_done   <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      // accept needs an empty hold, loads need a full one: never both in one clk
      if (accept) begin
        hold      <= tx_data;
        hold_full <= 1'b1;
      end
      if (fast_enable) begin
        if (state != ST_IDLE) cnt16 <= cnt16 + 4'd1;
        case (state)
          ST_IDLE: begin
            if (hold_full) begin
              state     <= ST_START;
              shift     <= hold;
              hold_full <= 1'b0;
              cnt16     <= 4'd0;
            end
          end
          ST_START: begin
            if (cell_end) begin
              state   <= ST_DATA;
              bit_idx <= 3'd0;
            end
          end
          ST_DATA: begin
            if (cell_end) begin
              shift <= shift >> 1;
              if (bit_idx == LAST_BIT) begin
                state    <= ST_STOP;
                stop_idx <= 1'b0;
              end else begin
                bit_idx <= bit_idx + 3'd1;
              end
            end
          end
          ST_STOP: begin
            if (cell_end) begin
              if (stop_idx == LAST_STOP) begin
                tx_done <= 1'b1;
                if (hold_full) begin
                  state     <= ST_START;
                  shift     <= hold;
                  hold_full <= 1'b0;
                end else begin
                  state <= ST_IDLE;
                end
              end else begin
                stop_idx <= stop_idx + 1'b1;
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  irda_sir_pulse_gen #(
    .PULSE_WIDTH      (PULSE_WIDTH),
    .MIN_PULSE_CYCLES (MIN_PULSE_CYCLES)
  ) u_pulse_gen (
    .clk       (clk),
    .wb_rst_i  (wb_rst_i),
    .sync_clr  (sync_clr),
    .zero_cell (zero_cell),
    .cnt16     (cnt16),
    .sir_enc_o (sir_enc_o)
  );

endmodule

// File: tb/tb_irda_sir_encoder.sv
// Self-checking bench for irda_sir_encoder: directed and random byte streams vs. a pulse-timeline model.
// Expected pulses derive from frame bit lists (start 0, data LSB first, stop 1) on a 16-tick cell grid.
// Also covers back-to-back chaining, fast_mode abort and asynchronous reset.
module tb_irda_sir_encoder;

  localparam int DATA_BITS        = 8;
  localparam int STOP_BITS        = 1;
  localparam int PULSE_WIDTH      = 3;
  localparam int MIN_PULSE_CYCLES = 8;
  localparam int CELLS            = 1 + DATA_BITS + STOP_BITS;

  logic       clk = 1'b0;
  logic       wb_rst_i;
  logic       fast_enable;
  logic       tx_select;
  logic       fast_mode;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       sir_enc_o;
  logic       tx_busy;
  logic       tx_done;

  int   checks = 0;
  int   errors = 0;
  int   tick_period = 4;
  bit   tick_en = 1'b0;
  int   cyc = 0;
  int   last_rise = 0;
  bit   sir_prev = 1'b0;
  int   rise_q[$];
  int   width_q[$];
  int   done_q[$];
  logic [7:0] txq[$];

  irda_sir_encoder #(
    .DATA_BITS        (DATA_BITS),
    .STOP_BITS        (STOP_BITS),
    .PULSE_WIDTH      (PULSE_WIDTH),
    .MIN_PULSE_CYCLES (MIN_PULSE_CYCLES)
  ) dut (
    .clk         (clk),
    .wb_rst_i    (wb_rst_i),
    .fast_enable (fast_enable),
    .tx_select   (tx_select),
    .fast_mode   (fast_mode),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .sir_enc_o   (sir_enc_o),
    .tx_busy     (tx_busy),
    .tx_done     (tx_done)
  );

  always #5 clk = ~clk;

  // 16x tick: one clk high every tick_period clks
  initial begin
    int div;
    div = 0;
    fast_enable = 1'b0;
    forever begin
      @(negedge clk);
      if (tick_en) begin
        div = (div + 1 >= tick_period) ? 0 : div + 1;
        fast_enable = (div == 0);
      end else begin
        div = 0;
        fast_enable = 1'b0;
      end
    end
  end

  // Record pulse rise times, widths and tx_done cycles
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (sir_enc_o === 1'b1 && !sir_prev) begin
      rise_q.push_back(cyc);
      last_rise = cyc;
    end
    if (sir_enc_o !== 1'b1 && sir_prev) width_q.push_back(cyc - last_rise);
    if (tx_done === 1'b1) done_q.push_back(cyc);
    sir_prev = (sir_enc_o === 1'b1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    rise_q.delete();
    width_q.delete();
    done_q.delete();
    txq.delete();
  endtask

  task automatic send_byte(input logic [7:0] b);
    int bound;
    bound = 5000;
    while (tx_ready !== 1'b1 && bound > 0) begin
      @(negedge clk);
      bound--;
    end
    chk("send_ready_wait", {31'd0, tx_ready === 1'b1}, 32'd1);
    tx_data  = b;
    tx_valid = 1'b1;
    txq.push_back(b);
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_pulse(input string tag);
    int bound;
    bound = 2000;
    while (sir_enc_o !== 1'b1 && bound > 0) begin
      @(negedge clk);
      bound--;
    end
    chk(tag, {31'd0, sir_enc_o === 1'b1}, 32'd1);
  endtask

  // Compare recorded pulses/dones against the frame model for everything in txq
  task automatic verify(input string tag);
    int n, bound, base, w_exp, np;
    int exp_rise[$];
    logic [7:0] cur;
    bit b;
    n = txq.size();
    bound = n * CELLS * 16 * tick_period + 2000;
    while (done_q.size() < n && bound > 0) begin
      @(negedge clk);
      bound--;
    end
    repeat (4 * tick_period + 4) @(negedge clk);
    chk({tag, "_done_count"}, done_q.size(), n);
`ifdef IRDA_SIR_MIN_PULSE_EN
    w_exp = MIN_PULSE_CYCLES;
`else
    w_exp = PULSE_WIDTH * tick_period;
`endif
    for (int f = 0; f < n; f++) begin
      cur = txq[f];
      for (int c = 0; c < CELLS; c++) begin
        if (c == 0) b = 1'b0;
        else if (c <= DATA_BITS) b = cur[c-1];
        else b = 1'b1;
        if (!b) exp_rise.push_back((f * CELLS + c) * 16 * tick_period);
      end
    end
    chk({tag, "_pulse_count"}, rise_q.size(), exp_rise.size());
    base = (rise_q.size() > 0) ? rise_q[0] : 0;
    np = (rise_q.size() < exp_rise.size()) ? rise_q.size() : exp_rise.size();
    for (int i = 0; i < np; i++) begin
      chk({tag, "_pulse_offset"}, rise_q[i] - base, exp_rise[i]);
      if (i < width_q.size()) chk({tag, "_pulse_width"}, width_q[i], w_exp);
    end
    for (int f = 0; f < done_q.size() && f < n; f++)
      chk({tag, "_done_offset"}, done_q[f] - base, (f + 1) * CELLS * 16 * tick_period - 1);
    chk({tag, "_busy_idle"}, {31'd0, tx_busy}, 32'd0);
    chk({tag, "_ready_idle"}, {31'd0, tx_ready}, 32'd1);
    txq.delete();
  endtask

  initial begin
    int r0;
    wb_rst_i  = 1'b1;
    tx_select = 1'b1;
    fast_mode = 1'b0;
    tx_data   = 8'd0;
    tx_valid  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_sir", {31'd0, sir_enc_o}, 32'd0);
    wb_rst_i = 1'b0;
    tick_en  = 1'b1;
    @(negedge clk);
    chk("rst_busy", {31'd0, tx_busy}, 32'd0);
    chk("rst_done", {31'd0, tx_done}, 32'd0);
    chk("rst_ready", {31'd0, tx_ready}, 32'd1);

    // Directed bytes
    tick_period = 4;
    clear_mon(); send_byte(8'h55); verify("b55");
    clear_mon(); send_byte(8'hFF); verify("bFF");
    clear_mon(); send_byte(8'h00); verify("b00");

    // Back-to-back: second byte offered while the first is in DATA
    clear_mon();
    send_byte(8'hA3);
    chk("b2b_ready_after_accept", {31'd0, tx_ready}, 32'd0);
    repeat (20 * tick_period) @(negedge clk);
    chk("b2b_busy_in_data", {31'd0, tx_busy}, 32'd1);
    chk("b2b_ready_in_data", {31'd0, tx_ready}, 32'd1);
    send_byte(8'h3C);
    chk("b2b_ready_held", {31'd0, tx_ready}, 32'd0);
    verify("b2b");

    // Random chained streams at random tick rates
    for (int r = 0; r < 3; r++) begin
      tick_period = $urandom_range(2, 5);
      clear_mon();
      for (int k = 0; k < 3; k++) send_byte(8'($urandom));
      verify("rand");
    end

    // fast_mode abort mid-pulse in DATA, with a byte held
    tick_period = 4;
    clear_mon();
    send_byte(8'h00);
    send_byte(8'h00);
    repeat (100) @(negedge clk);
    wait_pulse("abort_pulse_seen");
    fast_mode = 1'b1;
    @(negedge clk);
    chk("abort_sir", {31'd0, sir_enc_o}, 32'd0);
    chk("abort_busy", {31'd0, tx_busy}, 32'd0);
    chk("abort_ready", {31'd0, tx_ready}, 32'd0);
    repeat (50) @(negedge clk);
    chk("abort_ready_held", {31'd0, tx_ready}, 32'd0);
    fast_mode = 1'b0;
    @(negedge clk);
    chk("abort_hold_empty", {31'd0, tx_ready}, 32'd1);
    r0 = rise_q.size();
    repeat (300) @(negedge clk);
    chk("abort_no_restart", rise_q.size(), r0);
    chk("abort_stay_idle", {31'd0, tx_busy}, 32'd0);

    // Asynchronous reset mid-pulse
    clear_mon();
    send_byte(8'h00);
    wait_pulse("rst_pulse_seen");
    #1 wb_rst_i = 1'b1;
    #1;
    chk("arst_sir", {31'd0, sir_enc_o}, 32'd0);
    chk("arst_busy", {31'd0, tx_busy}, 32'd0);
    tx_select = 1'b0;
    @(negedge clk);
    wb_rst_i = 1'b0;
    @(negedge clk);
    chk("arst_rx_ready", {31'd0, tx_ready}, 32'd0);
    chk("arst_rx_busy", {31'd0, tx_busy}, 32'd0);
    tx_select = 1'b1;
    #1;
    chk("arst_tx_ready", {31'd0, tx_ready}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
